// File: rtl/sort4_cmp_sequencer.sv
// ============================================================================
// Module   : sort4_cmp_sequencer
// Brief    : 4-byte bubble sorter driving an external 8-bit magnitude comparator
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sort4_cmp_sequencer #(
  parameter bit DESCENDING = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic [7:0]  cmp_a,
  output logic [7:0]  cmp_b,
  input  logic [1:0]  cmp_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  swap_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SORT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] C_LAST_STEP = 3'd5;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_step;
  logic [3:0][7:0]  r_bytes;
  logic [2:0]       r_swap_count;
  logic [1:0]       w_idx;
  logic [1:0]       w_idx_hi;
  logic             w_load;
  logic             w_swap;

  // Fixed schedule: (0,1),(1,2),(2,3),(0,1),(1,2),(0,1)
  always_comb begin
    case (r_step)
      3'd0, 3'd3, 3'd5: w_idx = 2'd0;
      3'd1, 3'd4:       w_idx = 2'd1;
      default:          w_idx = 2'd2;
    endcase
  end

  assign w_idx_hi = w_idx + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    cmp_a       = 8'h00;
    cmp_b       = 8'h00;
    w_load      = 1'b0;
    w_swap      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = S_SORT;
        end
      end
      S_SORT: begin
        cmp_a = r_bytes[w_idx];
        cmp_b = r_bytes[w_idx_hi];
        // Equal results (bit 1 set, including the illegal 2'b11) never swap
        w_swap = DESCENDING ? (cmp_res == 2'b00) : (cmp_res == 2'b01);
        if (r_step == C_LAST_STEP) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step       <= 3'd0;
      r_bytes      <= '0;
      r_swap_count <= 3'd0;
    end else if (w_load) begin
      r_step       <= 3'd0;
      r_bytes      <= in_data;
      r_swap_count <= 3'd0;
    end else if (r_state == S_SORT) begin
      r_step <= r_step + 3'd1;
      if (w_swap) begin
        r_bytes[w_idx]    <= r_bytes[w_idx_hi];
        r_bytes[w_idx_hi] <= r_bytes[w_idx];
        r_swap_count      <= r_swap_count + 3'd1;
      end
    end
  end

  assign out_data   = r_bytes;
  assign swap_count = r_swap_count;

endmodule

`default_nettype wire

// File: tb/tb_sort4_cmp_sequencer.sv
// ============================================================================
// Module   : tb_sort4_cmp_sequencer
// Brief    : Scoreboard bench for sort4_cmp_sequencer (ascending + descending)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sort4_cmp_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [7:0]  cmp_a, cmp_b;
  logic [1:0]  cmp_res;
  logic [2:0]  swap_count;
  logic        force_eq;

  logic        d_in_valid, d_in_ready, d_out_valid;
  logic [31:0] d_in_data, d_out_data;
  logic [7:0]  d_cmp_a, d_cmp_b;
  logic [1:0]  d_cmp_res;
  logic [2:0]  d_swap_count;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [34:0] q_exp[$];
  logic [34:0] q_exp_d[$];

  // Comparator models: {A==B, A>B}, or forced to the illegal 2'b11
  assign cmp_res   = force_eq ? 2'b11 : {cmp_a == cmp_b, cmp_a > cmp_b};
  assign d_cmp_res = {d_cmp_a == d_cmp_b, d_cmp_a > d_cmp_b};

  sort4_cmp_sequencer #(.DESCENDING(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_res(cmp_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .swap_count(swap_count)
  );

  sort4_cmp_sequencer #(.DESCENDING(1'b1)) dut_d (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
    .cmp_a(d_cmp_a), .cmp_b(d_cmp_b), .cmp_res(d_cmp_res),
    .out_valid(d_out_valid), .out_ready(1'b1), .out_data(d_out_data),
    .swap_count(d_swap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor for the ascending instance: scoreboard pop plus latency check
  int  t_acc   = 0;
  bit  prev_ov = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) t_acc = cyc;
      if (out_valid && !prev_ov) chk("latency", cyc - t_acc, 32'd7);
      if (out_valid && out_ready) begin
        if (q_exp.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          logic [34:0] e;
          e = q_exp.pop_front();
          chk("out_data", out_data, e[31:0]);
          chk("swap_count", {29'd0, swap_count}, {29'd0, e[34:32]});
        end
      end
    end
    prev_ov = rst_n && out_valid;
  end

  always @(negedge clk) begin
    if (rst_n && d_out_valid) begin
      if (q_exp_d.size() == 0) begin
        chk("desc_unexpected_output", 32'd1, 32'd0);
      end else begin
        logic [34:0] e;
        e = q_exp_d.pop_front();
        chk("desc_out_data", d_out_data, e[31:0]);
        chk("desc_swap_count", {29'd0, d_swap_count}, {29'd0, e[34:32]});
      end
    end
  end

  // Presents a word, returns just after the accepting clock edge
  task automatic send(input logic [31:0] d, input logic [31:0] exp_d, input logic [2:0] exp_s);
    bit ok = 1'b0;
    q_exp.push_back({exp_s, exp_d});
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q_exp.size() != 0 || q_exp_d.size() != 0) && n < 200) begin
      @(posedge clk); n++;
    end
    if (n >= 200) chk("drain_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},   {31'd0, in_ready},   32'd1);
    chk({tag, "_out_valid"},  {31'd0, out_valid},  32'd0);
    chk({tag, "_out_data"},   out_data,            32'h0);
    chk({tag, "_swap_count"}, {29'd0, swap_count}, 32'd0);
    chk({tag, "_cmp_a"},      {24'd0, cmp_a},      32'd0);
    chk({tag, "_cmp_b"},      {24'd0, cmp_b},      32'd0);
  endtask

  initial begin
    logic [7:0] ea[6];
    logic [7:0] eb[6];
    ea = '{8'h04, 8'h04, 8'h04, 8'h03, 8'h03, 8'h02};
    eb = '{8'h03, 8'h02, 8'h01, 8'h02, 8'h01, 8'h01};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; force_eq = 1'b0;
    d_in_valid = 1'b0; d_in_data = '0;
    #12;
    chk_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    send(32'h01807FFF, 32'hFF807F01, 3'd5);
    drain();

    // Reversed word: also check operand pairs step by step
    send(32'h01020304, 32'h04030201, 3'd6);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("step%0d_cmp_a", k), {24'd0, cmp_a}, {24'd0, ea[k]});
      chk($sformatf("step%0d_cmp_b", k), {24'd0, cmp_b}, {24'd0, eb[k]});
    end
    drain();
    chk("idle_cmp_a", {24'd0, cmp_a}, 32'd0);

    send(32'h04030201, 32'h04030201, 3'd0);
    send(32'hAAAAAAAA, 32'hAAAAAAAA, 3'd0);
    drain();

    force_eq = 1'b1;
    send(32'h01020304, 32'h01020304, 3'd0);
    drain();
    force_eq = 1'b0;

    q_exp_d.push_back({3'd6, 32'h01020304});
    d_in_valid = 1'b1; d_in_data = 32'h04030201;
    @(posedge clk); #1 d_in_valid = 1'b0;
    drain();

    // Backpressure: hold DONE while a new word waits at the input
    out_ready = 1'b0;
    send(32'h04030201, 32'h04030201, 3'd0);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      if (!seen) chk("done_timeout", 32'd1, 32'd0);
    end
    q_exp.push_back({3'd6, 32'h04030201});
    in_valid = 1'b1; in_data = 32'h01020304;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_data",   out_data,            32'h04030201);
      chk("bp_swap_count", {29'd0, swap_count}, 32'd0);
      chk("bp_in_ready",   {31'd0, in_ready},   32'd0);
      chk("bp_out_valid",  {31'd0, out_valid},  32'd1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    drain();

    // Reset during SORT step 3
    send(32'h01020304, 32'h04030201, 3'd6);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_swaps", {29'd0, swap_count}, 32'd3);
    #1 rst_n = 1'b0;
    q_exp.delete();
    #1;
    chk_reset_outputs("midsort_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    send(32'h01807FFF, 32'hFF807F01, 3'd5);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
